sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single 1 MHz-side SDRAM command port between two requesters: CPU on port 0, loader/DMA on port 1.
- Accepts one write or read per grant and issues it as a one-cycle pulse on ram_wr_en or ram_rd_en.
- Keeps an in-order tag FIFO of outstanding reads, so each returning read word is routed to the requester that issued it.
- Sits between the processor-side masters and sdram_block, in the mclk domain.

Parameters:
ADDR_W, 24, address width, matches ram_addr
DATA_W, 16, data width, matches ram_wr_data/ram_rd_data
TAG_DEPTH, 8, max outstanding reads; power of 2, >= 2

Ports:
clk  in  1  system clock (mclk domain)
rst  in  1  asynchronous, active-high reset
rq0_addr  in  ADDR_W  requester 0 address
rq0_wdata  in  DATA_W  requester 0 write data
rq0_we  in  1  requester 0 write request, held until grant
rq0_re  in  1  requester 0 read request, held until grant
rq0_gnt  out  1  requester 0 request accepted this cycle
rq0_rdata  out  DATA_W  requester 0 read data
rq0_rvalid  out  1  requester 0 read data valid, one-cycle pulse
rq1_addr, rq1_wdata, rq1_we, rq1_re, rq1_gnt, rq1_rdata, rq1_rvalid  same as port 0, for requester 1
ram_addr  out  ADDR_W  to sdram_block
ram_wr_data  out  DATA_W  to sdram_block
ram_wr_en  out  1  write push, one-cycle pulse
ram_rd_en  out  1  read-address push, one-cycle pulse
ram_busy  in  1  SDRAM FIFOs full
ram_rd_ready  in  1  read-data FIFO non-empty
ram_rd_data  in  DATA_W  read-data FIFO head
ram_rd_ack  out  1  pop read-data FIFO, one-cycle pulse
err  out  1  sticky: read data arrived with no outstanding tag

Behaviour:
- Reset (async): all outputs 0; issue FSM = IDLE; return FSM = R_IDLE; tag FIFO empty; rr_last = 1, so port 0 wins first contention.
- Request eligibility:
  - A requester is eligible when we or re is high.
  - we and re both high: treated as a write; re ignored for that grant.
  - Reads are additionally eligible only when the tag FIFO is not full.
- Issue FSM (IDLE, ISSUE):
  - IDLE: if ram_busy = 0 and at least one requester is eligible, pick the winner.
    - Contention: the port != rr_last wins.
    - Assert rqN_gnt combinationally in that same cycle, update rr_last = N, register addr/data/op, go to ISSUE.
  - ISSUE: drive registered ram_addr/ram_wr_data plus exactly one of ram_wr_en/ram_rd_en for this one cycle.
    - On a read, push tag N.
    - Return to IDLE.
    - No grant in ISSUE: the mandatory gap lets the FIFO full flag settle.
  - Peak throughput: 1 access per 2 cycles.
  - ram_busy is sampled only in IDLE; once granted, an access always issues.
  - Requester must drop or change its request the cycle after gnt; a still-high request the next cycle is a new request.
- Return FSM (R_IDLE, R_WAIT):
  - R_IDLE: if ram_rd_ready = 1, assert ram_rd_ack for 1 cycle and go to R_WAIT.
    - If tag FIFO non-empty: pop head tag T; next cycle rqT_rdata = ram_rd_data captured in the ack cycle, and rqT_rvalid pulses 1 cycle.
    - If tag FIFO empty: drain the word, drop it, set err.
  - R_WAIT: one cycle, no ack, so empty_n can update; then R_IDLE.
  - rqN_rdata holds its last value between pulses.
- Concurrency:
  - Tag push (ISSUE) and pop (R_IDLE ack) in the same cycle are both honoured; occupancy unchanged.
  - Tag FIFO is a circular buffer; pointers are log2(TAG_DEPTH)+1 bits with wrap-around.
- Ordering: reads are returned strictly in issue order across both ports.
- Reset mid-operation: outstanding tags are lost. Orphaned SDRAM read data returned later is drained via the err path; err clears only on rst.

Optional Feature:
Macro SDRAM_ARB_PRIO_EN.
- Defined: fixed priority, port 0 always wins contention; rr_last is not implemented. Port 1 can starve.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Only rq0_we=1, addr 0x000010, wdata 0xBEEF -> rq0_gnt in cycle T, ram_wr_en=1 with addr 0x000010/data 0xBEEF in T+1, no other pulses.
- rq0_re and rq1_re both held high for 4 grants -> grants alternate 0,1,0,1. Model returns 0x1111, 0x2222, 0x3333, 0x4444 -> rq0 gets 0x1111 and 0x3333, rq1 gets 0x2222 and 0x4444, each via rvalid.
- ram_busy=1 for 10 cycles with rq1_we high -> no gnt and no ram_wr_en; busy drops -> gnt in the next cycle.
- Issue 8 reads with no returns -> 9th read is not granted while a write from the other port is still granted. One return -> 9th read granted.
- ram_rd_ready=1 with no outstanding reads -> ram_rd_ack pulses once, no rvalid, err=1 until rst.
- With SDRAM_ARB_PRIO_EN defined, both ports request continuously -> port 0 receives every grant.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-port SDRAM command arbiter with in-order read-tag routing (mclk domain).
// Define SDRAM_ARB_PRIO_EN for fixed priority (port 0 always wins); default is round-robin.
module sdram_arbiter #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic              rq0_we,
  input  logic              rq0_re,
  output logic              rq0_gnt,
  output logic [DATA_W-1:0] rq0_rdata,
  output logic              rq0_rvalid,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  input  logic              rq1_we,
  input  logic              rq1_re,
  output logic              rq1_gnt,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic              rq1_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  input  logic              ram_busy,
  input  logic              ram_rd_ready,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              ram_rd_ack,
  output logic              err
);

  localparam int unsigned AW = $clog2(TAG_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {IDLE, ISSUE}    issue_state_t;
  typedef enum logic {R_IDLE, R_WAIT} ret_state_t;

  issue_state_t st_q, st_d;
  ret_state_t   rs_q, rs_d;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          tag_mem [TAG_DEPTH];
  logic          tag_full, tag_empty, tag_push, tag_pop, head_tag;

  logic elig0, elig1, take, pick1;
  logic op_wr, op_port;

  assign tag_empty = (wr_ptr == rd_ptr);
  assign tag_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_tag  = tag_mem[rd_ptr[AW-1:0]];

  // A write wins over a simultaneous read; reads wait while no tag slot is free.
  assign elig0 = rq0_we | (rq0_re & ~tag_full);
  assign elig1 = rq1_we | (rq1_re & ~tag_full);

`ifndef SDRAM_ARB_PRIO_EN
  logic rr_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rr_last <= 1'b1;
    else if (take) rr_last <= pick1;
  end
`endif

  always_comb begin
    st_d    = st_q;
    take    = 1'b0;
    pick1   = 1'b0;
    rq0_gnt = 1'b0;
    rq1_gnt = 1'b0;
    case (st_q)
      IDLE: begin
        if (!ram_busy && (elig0 || elig1)) begin
          take = 1'b1;
`ifdef SDRAM_ARB_PRIO_EN
          pick1 = ~elig0;
`else
          pick1 = elig1 & (~elig0 | ~rr_last);
`endif
          rq0_gnt = ~pick1;
          rq1_gnt = pick1;
          st_d    = ISSUE;
        end
      end
      ISSUE:   st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= IDLE;
      op_wr       <= 1'b0;
      op_port     <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else begin
      st_q <= st_d;
      if (take) begin
        op_port     <= pick1;
        op_wr       <= pick1 ? rq1_we    : rq0_we;
        ram_addr    <= pick1 ? rq1_addr  : rq0_addr;
        ram_wr_data <= pick1 ? rq1_wdata : rq0_wdata;
      end
    end
  end

  assign ram_wr_en = (st_q == ISSUE) &  op_wr;
  assign ram_rd_en = (st_q == ISSUE) & ~op_wr;
  assign tag_push  = ram_rd_en;

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[wr_ptr[AW-1:0]] <= op_port;
  end

  always_comb begin
    rs_d       = rs_q;
    ram_rd_ack = 1'b0;
    case (rs_q)
      R_IDLE: begin
        if (ram_rd_ready) begin
          ram_rd_ack = 1'b1;
          rs_d       = R_WAIT;
        end
      end
      R_WAIT:  rs_d = R_IDLE;
      default: rs_d = R_IDLE;
    endcase
  end

  assign tag_pop = ram_rd_ack & ~tag_empty;

  // Push and pop may coincide; each pointer advances independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q       <= R_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rq0_rdata  <= '0;
      rq1_rdata  <= '0;
      rq0_rvalid <= 1'b0;
      rq1_rvalid <= 1'b0;
      err        <= 1'b0;
    end else begin
      rs_q       <= rs_d;
      rq0_rvalid <= tag_pop & ~head_tag;
      rq1_rvalid <= tag_pop &  head_tag;
      if (tag_push) wr_ptr <= wr_ptr + PW'(1);
      if (tag_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (head_tag) rq1_rdata <= ram_rd_data;
        else          rq0_rdata <= ram_rd_data;
      end
      if (ram_rd_ack && tag_empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard testbench for sdram_arbiter: issue, routing, back-pressure, tag-full and orphan paths.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] rq0_addr = '0, rq1_addr = '0;
  logic [15:0] rq0_wdata = '0, rq1_wdata = '0;
  logic        rq0_we = 1'b0, rq0_re = 1'b0, rq1_we = 1'b0, rq1_re = 1'b0;
  logic        rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid;
  logic [15:0] rq0_rdata, rq1_rdata;
  logic [23:0] ram_addr;
  logic [15:0] ram_wr_data;
  logic        ram_wr_en, ram_rd_en, ram_rd_ack, err;
  logic        ram_busy = 1'b0, ram_rd_ready = 1'b0;
  logic [15:0] ram_rd_data = '0;

  sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .TAG_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rq0_we(rq0_we), .rq0_re(rq0_re),
    .rq0_gnt(rq0_gnt), .rq0_rdata(rq0_rdata), .rq0_rvalid(rq0_rvalid),
    .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rq1_we(rq1_we), .rq1_re(rq1_re),
    .rq1_gnt(rq1_gnt), .rq1_rdata(rq1_rdata), .rq1_rvalid(rq1_rvalid),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_busy(ram_busy), .ram_rd_ready(ram_rd_ready), .ram_rd_data(ram_rd_data),
    .ram_rd_ack(ram_rd_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
    logic [15:0] data;
  } iss_t;

  iss_t        exp_iss[$];
  int          exp_tags[$];
  logic [15:0] exp_rd0[$], exp_rd1[$];
  int          gnt_log[$];
  int          n_checks = 0, n_errors = 0;
  int          g0_cnt = 0, g1_cnt = 0, rv0_cnt = 0, rv1_cnt = 0, ack_cnt = 0;
  logic        gnt_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: builds expected issues from grants, checks issue timing/content and read routing.
  always @(negedge clk) begin
    iss_t        e;
    logic [15:0] d;
    if (rst) begin
      gnt_prev = 1'b0;
    end else begin
      check("issue_latency", 32'(ram_wr_en | ram_rd_en), 32'(gnt_prev));
      check("wr_rd_excl", 32'(ram_wr_en & ram_rd_en), 0);
      if ((ram_wr_en || ram_rd_en) && exp_iss.size() > 0) begin
        e = exp_iss.pop_front();
        check("issue_op_wr", 32'(ram_wr_en), 32'(e.wr));
        check("issue_addr", 32'(ram_addr), 32'(e.addr));
        if (e.wr) check("issue_wdata", 32'(ram_wr_data), 32'(e.data));
      end
      check("gnt_onehot", 32'(rq0_gnt & rq1_gnt), 0);
      if (rq0_gnt) begin
        exp_iss.push_back('{wr: rq0_we, addr: rq0_addr, data: rq0_wdata});
        gnt_log.push_back(0);
        g0_cnt++;
        if (!rq0_we) exp_tags.push_back(0);
      end
      if (rq1_gnt) begin
        exp_iss.push_back('{wr: rq1_we, addr: rq1_addr, data: rq1_wdata});
        gnt_log.push_back(1);
        g1_cnt++;
        if (!rq1_we) exp_tags.push_back(1);
      end
      gnt_prev = rq0_gnt | rq1_gnt;
      if (ram_rd_ack) ack_cnt++;
      if (rq0_rvalid) begin
        rv0_cnt++;
        if (exp_rd0.size() > 0) begin
          d = exp_rd0.pop_front();
          check("rq0_rdata", 32'(rq0_rdata), 32'(d));
        end else check("rq0_rvalid_unexpected", 1, 0);
      end
      if (rq1_rvalid) begin
        rv1_cnt++;
        if (exp_rd1.size() > 0) begin
          d = exp_rd1.pop_front();
          check("rq1_rdata", 32'(rq1_rdata), 32'(d));
        end else check("rq1_rvalid_unexpected", 1, 0);
      end
    end
  end

  task automatic set_req(input int p, input logic we, input logic re,
                         input logic [23:0] a, input logic [15:0] d);
    if (p == 0) begin rq0_we = we; rq0_re = re; rq0_addr = a; rq0_wdata = d; end
    else        begin rq1_we = we; rq1_re = re; rq1_addr = a; rq1_wdata = d; end
  endtask

  task automatic wait_gnt(input int p);
    logic got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? rq0_gnt : rq1_gnt;
    end
    if (!got) check("gnt_timeout", 0, 1);
  endtask

  task automatic request(input int p, input logic we, input logic re,
                         input logic [23:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    set_req(p, we, re, a, d);
    wait_gnt(p);
    @(posedge clk); #1;
    set_req(p, 1'b0, 1'b0, a, d);
  endtask

  // SDRAM returns one word; the expected destination is the oldest outstanding read.
  task automatic ret_word(input logic [15:0] d);
    logic got = 1'b0;
    int   p;
    @(posedge clk); #1;
    if (exp_tags.size() > 0) begin
      p = exp_tags.pop_front();
      if (p == 0) exp_rd0.push_back(d);
      else        exp_rd1.push_back(d);
    end
    ram_rd_ready = 1'b1;
    ram_rd_data  = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = ram_rd_ack;
    end
    if (!got) check("ack_timeout", 0, 1);
    @(posedge clk); #1;
    ram_rd_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, 32'({rq0_gnt, rq1_gnt}), 0);
    check({tag, "_en"}, 32'({ram_wr_en, ram_rd_en, ram_rd_ack}), 0);
    check({tag, "_rvalid"}, 32'({rq0_rvalid, rq1_rvalid}), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_addr"}, 32'(ram_addr), 0);
    check({tag, "_rdata"}, 32'({rq0_rdata, rq1_rdata}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[4];
    int n, g0_before, ack_before, rv_before;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Both ports read continuously: round-robin alternates, port 0 first.
`ifdef SDRAM_ARB_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b1, 24'h000100, 16'h0);
    set_req(1, 1'b0, 1'b1, 24'h000200, 16'h0);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (rq0_gnt || rq1_gnt) n++;
    end
    check("rr_grant_count", n, 4);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 24'h0, 16'h0);
    set_req(1, 1'b0, 1'b0, 24'h0, 16'h0);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_order_%0d", i), (gnt_log.size() > i) ? gnt_log[i] : -1, exp_order[i]);
    ret_word(16'h1111);
    ret_word(16'h2222);
    ret_word(16'h3333);
    ret_word(16'h4444);
`ifdef SDRAM_ARB_PRIO_EN
    check("rr_rv0_count", rv0_cnt, 4);
    check("rr_rv1_count", rv1_cnt, 0);
`else
    check("rr_rv0_count", rv0_cnt, 2);
    check("rr_rv1_count", rv1_cnt, 2);
`endif

    // Single write from port 0.
    request(0, 1'b1, 1'b0, 24'h000010, 16'hBEEF);
    check("wr_gnt_port", gnt_log[gnt_log.size()-1], 0);

    // Back-pressure: no grant while busy, grant as soon as it drops.
    @(posedge clk); #1;
    ram_busy = 1'b1;
    set_req(1, 1'b1, 1'b0, 24'h003000, 16'h5A5A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("busy_no_gnt", 32'(rq1_gnt), 0);
    end
    @(posedge clk); #1;
    ram_busy = 1'b0;
    @(negedge clk);
    check("busy_release_gnt", 32'(rq1_gnt), 1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 24'h0, 16'h0);

    // Fill all 8 tags, then a 9th read must wait while a write still gets through.
    for (int i = 0; i < 8; i++)
      request(0, 1'b0, 1'b1, 24'h000400 + 24'(i), 16'h0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b1, 24'h000500, 16'h0);
    set_req(1, 1'b1, 1'b0, 24'h000600, 16'h1234);
    wait_gnt(1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 24'h0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("full_no_gnt0", 32'(rq0_gnt), 0);
    end
    g0_before = g0_cnt;
    ret_word(16'hA000);
    check("ninth_read_gnt", g0_cnt - g0_before, 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 24'h0, 16'h0);
    for (int i = 1; i <= 8; i++)
      ret_word(16'hA000 + 16'(i));

    // Orphan return: drained once, no rvalid, sticky err.
    check("err_before_orphan", 32'(err), 0);
    ack_before = ack_cnt;
    rv_before  = rv0_cnt + rv1_cnt;
    ret_word(16'hDEAD);
    check("orphan_ack_once", ack_cnt - ack_before, 1);
    check("orphan_no_rvalid", rv0_cnt + rv1_cnt - rv_before, 0);
    check("orphan_err", 32'(err), 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("err_sticky", 32'(err), 1);

    // Reset clears the sticky error.
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("err_after_rst", 32'(err), 0);

    check("left_exp_iss", exp_iss.size(), 0);
    check("left_exp_tags", exp_tags.size(), 0);
    check("left_exp_rd0", exp_rd0.size(), 0);
    check("left_exp_rd1", exp_rd1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
